// File: rtl/cp_insert_if.sv
// AXI-Stream style beat channel used on both sides of the cyclic-prefix inserter.
// The master drives data/last/valid; the slave returns ready.
interface cp_insert_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: buffers one frame, then replays its tail (CP) followed by the whole frame.
//   state  | meaning
//   S_FILL | accepting frame_len input beats into the buffer
//   S_CP   | emitting buf[frame_len-cp .. frame_len-1]
//   S_BODY | emitting buf[0 .. frame_len-1], tlast on the final beat
module cp_insert #(
    parameter int WIDTH        = 32,
    parameter int MAX_LEN_LOG2 = 8,
    parameter int SR_FRAME_LEN = 16,
    parameter int SR_CP_LEN    = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    cp_insert_if.slave  i_axis,
    cp_insert_if.master o_axis,
    output logic        misalign
);
    localparam int L        = MAX_LEN_LOG2;
    localparam int DEF_FL_I = (L >= 6) ? 64 : (1 << L);
    localparam int DEF_CP_I = (DEF_FL_I < 16) ? DEF_FL_I : 16;
    localparam logic [L:0] MAX_LEN = {1'b1, {L{1'b0}}};
    localparam logic [L:0] DEF_FL  = DEF_FL_I[L:0];
    localparam logic [L:0] DEF_CP  = DEF_CP_I[L:0];
    localparam logic [L:0] ONE     = {{L{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_FILL, S_CP, S_BODY} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_buf [2**L];
    logic [L:0]       r_fl_sh, r_cp_sh, r_fl, r_cp;
    logic [L:0]       r_wr, r_rd;
    logic [L:0]       w_set_val, w_fl_wr, w_fl_sh_nxt, w_cp_sh_nxt, w_cp_clamp;
    logic [L:0]       w_fl, w_cp, w_raddr;
    logic             w_load, w_in_hs, w_out_hs;
    logic             w_wr_last, w_cp_last, w_body_last;
    logic             w_unused_bits;

    assign w_set_val   = set_data[L:0];
    assign w_fl_wr     = (w_set_val == '0 || w_set_val > MAX_LEN) ? MAX_LEN : w_set_val;
    assign w_fl_sh_nxt = (set_stb && set_addr == 8'(SR_FRAME_LEN)) ? w_fl_wr : r_fl_sh;
    assign w_cp_sh_nxt = (set_stb && set_addr == 8'(SR_CP_LEN)) ? w_set_val : r_cp_sh;
    assign w_cp_clamp  = (w_cp_sh_nxt > w_fl_sh_nxt) ? w_fl_sh_nxt : w_cp_sh_nxt;

    // Active config keeps following the shadow until the first beat of a frame is taken.
    assign w_load = (r_state == S_FILL) && (r_wr == '0);
    assign w_fl   = w_load ? w_fl_sh_nxt : r_fl;
    assign w_cp   = w_load ? w_cp_clamp  : r_cp;

    assign w_in_hs     = i_axis.tvalid && i_axis.tready;
    assign w_out_hs    = o_axis.tvalid && o_axis.tready;
    assign w_wr_last   = (r_wr == w_fl - ONE);
    assign w_cp_last   = (r_rd == r_cp - ONE);
    assign w_body_last = (r_rd == r_fl - ONE);

    assign w_raddr      = (r_state == S_CP) ? (r_fl - r_cp + r_rd) : r_rd;
    assign o_axis.tdata = o_axis.tvalid ? r_buf[w_raddr[L-1:0]] : '0;

    assign w_unused_bits = ^{set_data, w_raddr[L]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        i_axis.tready = 1'b0;
        o_axis.tvalid = 1'b0;
        o_axis.tlast  = 1'b0;
        case (r_state)
            S_FILL: begin
                i_axis.tready = 1'b1;
                if (i_axis.tvalid && w_wr_last)
                    w_state_nxt = (w_cp == '0) ? S_BODY : S_CP;
            end
            S_CP: begin
                o_axis.tvalid = 1'b1;
                if (o_axis.tready && w_cp_last) w_state_nxt = S_BODY;
            end
            S_BODY: begin
                o_axis.tvalid = 1'b1;
                o_axis.tlast  = w_body_last;
                if (o_axis.tready && w_body_last) w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fl_sh <= DEF_FL;
            r_cp_sh <= DEF_CP;
            r_fl    <= DEF_FL;
            r_cp    <= DEF_CP;
        end else begin
            r_fl_sh <= w_fl_sh_nxt;
            r_cp_sh <= w_cp_sh_nxt;
            if (w_load) begin
                r_fl <= w_fl;
                r_cp <= w_cp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr     <= '0;
            r_rd     <= '0;
            misalign <= 1'b0;
        end else begin
            if (r_state == S_FILL && w_in_hs) begin
                r_wr <= w_wr_last ? '0 : r_wr + ONE;
                if (i_axis.tlast != w_wr_last) misalign <= 1'b1;
            end
            if (r_state == S_CP && w_out_hs)
                r_rd <= w_cp_last ? '0 : r_rd + ONE;
            if (r_state == S_BODY && w_out_hs)
                r_rd <= w_body_last ? '0 : r_rd + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) r_buf[r_wr[L-1:0]] <= i_axis.tdata;
    end
endmodule

// File: tb/tb_cp_insert.sv
// Scoreboard bench for cp_insert: each frame's expected CP+body sequence is queued at issue time
// and a negedge monitor pops and compares every output handshake.
module tb_cp_insert;
    localparam int WIDTH = 32;
    localparam int MAXL  = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        misalign;

    cp_insert_if #(.WIDTH(WIDTH)) in_if ();
    cp_insert_if #(.WIDTH(WIDTH)) out_if ();

    cp_insert #(.WIDTH(WIDTH), .MAX_LEN_LOG2(8), .SR_FRAME_LEN(16), .SR_CP_LEN(17)) dut (
        .clk      (clk),
        .reset    (reset),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .i_axis   (in_if),
        .o_axis   (out_if),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;

    beat_t            exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               pops     = 0;
    int               m_fl_sh  = 64;
    int               m_cp_sh  = 16;
    bit               m_mis    = 0;
    bit               rand_ready = 0;
    bit               held = 0;
    logic [WIDTH-1:0] held_d;
    logic             held_l;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: values are stable at negedge; a valid&&ready seen here transfers on the next posedge.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            held = 0;
        end else if (out_if.tvalid) begin
            if (held) begin
                check("stall_data", 64'(out_if.tdata), 64'(held_d));
                check("stall_last", 64'(out_if.tlast), 64'(held_l));
            end
            if (out_if.tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0h with no beat expected", out_if.tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_if.tdata), 64'(e.d));
                    check("out_last", 64'(out_if.tlast), 64'(e.l));
                end
                pops++;
                held = 0;
            end else begin
                held   = 1;
                held_d = out_if.tdata;
                held_l = out_if.tlast;
            end
        end else begin
            held = 0;
        end
    end

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic sr_write(input int addr, input int val);
        logic [31:0] v;
        v = val;
        @(posedge clk);
        #1;
        set_stb  = 1'b1;
        set_addr = addr[7:0];
        set_data = v;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
        if (addr == 16) m_fl_sh = (v[8:0] == 0 || v[8:0] > MAXL) ? MAXL : int'(v[8:0]);
        if (addr == 17) m_cp_sh = int'(v[8:0]);
    endtask

    // Config in effect is whatever was written before the frame's first beat is offered.
    task automatic send_frame(input int bad_idx, input bit ramp, input bit rand_valid);
        int fl, cp, i, budget;
        logic [WIDTH-1:0] d[];
        fl = m_fl_sh;
        cp = (m_cp_sh < fl) ? m_cp_sh : fl;
        d  = new[fl];
        for (int k = 0; k < fl; k++) d[k] = ramp ? WIDTH'(k) : WIDTH'($urandom);
        for (int k = 0; k < cp; k++) exp_q.push_back('{d: d[fl - cp + k], l: 1'b0});
        for (int k = 0; k < fl; k++) exp_q.push_back('{d: d[k], l: (k == fl - 1)});
        if (bad_idx >= 0 && bad_idx != fl - 1) m_mis = 1;
        i = 0;
        budget = 0;
        while (i < fl && budget < 20000) begin
            @(posedge clk);
            #1;
            in_if.tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            in_if.tdata  = d[i];
            in_if.tlast  = (i == fl - 1) != (i == bad_idx);
            @(negedge clk);
            if (in_if.tvalid && in_if.tready) i++;
            budget++;
        end
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        if (i < fl) begin
            n_checks++;
            n_fail++;
            $display("FAIL input_timeout: accepted %0d beats required %0d", i, fl);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40000) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        check("idle_valid", 64'(out_if.tvalid), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_if.tvalid = 1'b0;
        exp_q.delete();
        m_fl_sh = 64;
        m_cp_sh = 16;
        m_mis   = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int budget, target;
        reset        = 1'b1;
        set_stb      = 1'b0;
        set_addr     = '0;
        set_data     = '0;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_i_tready", 64'(in_if.tready), 64'd1);
        check("rst_o_tvalid", 64'(out_if.tvalid), 64'd0);
        check("rst_o_tlast", 64'(out_if.tlast), 64'd0);
        check("rst_o_tdata", 64'(out_if.tdata), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);

        // Defaults: 64-sample ramp, CP 16
        send_frame(-1, 1, 0);
        drain();
        check("default_misalign", 64'(misalign), 64'd0);

        // No CP
        sr_write(17, 0);
        sr_write(16, 8);
        send_frame(-1, 1, 0);
        drain();

        // CP longer than frame clamps to frame length
        sr_write(17, 20);
        send_frame(-1, 1, 0);
        drain();

        // Random config, random valid/ready, back-to-back frames
        rand_ready = 1;
        for (int f = 0; f < 10; f++) begin
            case (f)
                3:       sr_write(16, 0);
                6:       sr_write(16, 300);
                8:       sr_write(16, 1);
                default: sr_write(16, $urandom_range(1, 40));
            endcase
            sr_write(17, $urandom_range(0, 50));
            send_frame(-1, 0, 1);
        end
        drain();
        rand_ready = 0;
        check("random_misalign", 64'(misalign), 64'd0);

        // Frame length write during CP affects only the next frame
        sr_write(16, 64);
        sr_write(17, 16);
        send_frame(-1, 1, 0);
        budget = 0;
        while (!out_if.tvalid && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        check("cp_seen_for_write", 64'(out_if.tvalid), 64'd1);
        sr_write(16, 32);
        send_frame(-1, 0, 0);
        drain();

        // Misplaced tlast: sticky flag, framing unaffected
        sr_write(16, 64);
        send_frame(10, 1, 0);
        drain();
        check("misalign_set", 64'(misalign), 64'(m_mis));
        send_frame(-1, 0, 0);
        drain();
        check("misalign_sticky", 64'(misalign), 64'(m_mis));

        // Reset while in BODY discards the rest of the frame
        send_frame(-1, 0, 0);
        target = pops + 16 + 5;
        budget = 0;
        while (pops < target && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("body_reached", 64'(pops >= target), 64'd1);
        do_reset();
        check("post_rst_valid", 64'(out_if.tvalid), 64'd0);
        check("post_rst_misalign", 64'(misalign), 64'd0);
        check("post_rst_ready", 64'(in_if.tready), 64'd1);
        send_frame(-1, 1, 0);
        drain();
        check("final_misalign", 64'(misalign), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
